// File: rtl/aes_128_ctr.sv
// AES-128 counter-mode stream engine plus the iterative aes_128 core it drives.
// The core runs one round per cycle; the wrapper pre-computes keystream into a small FIFO.

module aes_128 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ready,
  input  logic [127:0] key,
  input  logic [127:0] in_bus,
  output logic         valid,
  output logic [127:0] out_bus
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box as the GF(2^8) inverse (x^254, with 0 -> 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = sbox(v[8*i +: 8]);
    return o;
  endfunction

  // Byte 0 is the MSB; state[r][c] is byte r+4c
  function automatic logic [127:0] shift_rows(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = v[127-32*c -: 8];
      a1 = v[119-32*c -: 8];
      a2 = v[111-32*c -: 8];
      a3 = v[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {rc, 24'h000000};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] st, rk, rk_next, sr, round_out;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic         run;

  always_comb begin
    rk_next   = next_key(rk, rcon);
    sr        = shift_rows(sub_bytes(st));
    round_out = ((rnd == 4'd10) ? sr : mix_columns(sr)) ^ rk_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= '0;
      rk      <= '0;
      rcon    <= '0;
      rnd     <= '0;
      run     <= 1'b0;
      valid   <= 1'b0;
      out_bus <= '0;
    end else begin
      valid <= 1'b0;
      if (ready) begin
        st   <= in_bus ^ key;
        rk   <= key;
        rcon <= 8'h01;
        rnd  <= 4'd1;
        run  <= 1'b1;
      end else if (run) begin
        st   <= round_out;
        rk   <= rk_next;
        rcon <= xtime(rcon);
        rnd  <= rnd + 4'd1;
        if (rnd == 4'd10) begin
          run     <= 1'b0;
          valid   <= 1'b1;
          out_bus <= round_out;
        end
      end
    end
  end

endmodule

module aes_128_ctr #(
  parameter int unsigned CTR_W    = 32,
  parameter int unsigned KS_DEPTH = 4,
  parameter int unsigned CORE_LAT = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic         busy,
  output logic         err_timeout
);

  localparam int unsigned AW       = $clog2(KS_DEPTH);
  localparam int unsigned WD_LIMIT = 4 * CORE_LAT;
  localparam int unsigned WDW      = $clog2(WD_LIMIT + 1);
  localparam logic [AW:0]     DEPTH    = (AW+1)'(KS_DEPTH);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(WD_LIMIT - 1);
  localparam logic [127:0]    CTR_MASK = (128'd1 << CTR_W) - 128'd1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]     state;
  logic [127:0]   key_r, ctr, ctr_inc;
  logic           epoch, launch_epoch, draining;
  logic [WDW-1:0] wd_cnt;
  logic [127:0]   ks_mem [KS_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    ks_count, count_after;
  logic [127:0]   head, core_out;
  logic           core_ready, core_valid, rst_n;
  logic           accept, last_acc, push;

  always_comb begin
    rst_n       = ~rst;
    head        = ks_mem[rd_ptr];
    s_ready     = (ks_count != '0) && (!m_valid || m_ready) && (state != S_IDLE) && !draining;
    accept      = s_valid && s_ready;
    last_acc    = accept && s_last;
    // A core result is kept only for the launch of the current message
    push        = (state == S_WAIT) && core_valid && (launch_epoch == epoch) &&
                  !draining && !cfg_load && !last_acc;
    count_after = ks_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, accept};
    ctr_inc     = (ctr & ~CTR_MASK) | ((ctr + 128'd1) & CTR_MASK);
    core_ready  = (state == S_LAUNCH);
    busy        = (state != S_IDLE);
  end

  aes_128 u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .ready   (core_ready),
    .key     (key_r),
    .in_bus  (ctr),
    .valid   (core_valid),
    .out_bus (core_out)
  );

  always_ff @(posedge clk) begin
    if (push) ks_mem[wr_ptr] <= core_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      key_r        <= '0;
      ctr          <= '0;
      epoch        <= 1'b0;
      launch_epoch <= 1'b0;
      draining     <= 1'b0;
      wd_cnt       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ks_count     <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (accept) begin
        m_data  <= s_data ^ head;
        m_last  <= s_last;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (cfg_load) begin
        key_r       <= cfg_key;
        ctr         <= cfg_iv;
        epoch       <= ~epoch;
        draining    <= 1'b0;
        err_timeout <= 1'b0;
        wd_cnt      <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        ks_count    <= '0;
        state       <= S_LAUNCH;
      end else if (last_acc) begin
        // Parked in HOLD with launches blocked until the final beat leaves
        draining <= 1'b1;
        wd_cnt   <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        ks_count <= '0;
        state    <= S_HOLD;
      end else begin
        if (push)   wr_ptr <= wr_ptr + AW'(1);
        if (accept) rd_ptr <= rd_ptr + AW'(1);
        ks_count <= count_after;
        case (state)
          S_LAUNCH: begin
            launch_epoch <= epoch;
            wd_cnt       <= '0;
            state        <= S_WAIT;
          end
          S_WAIT: begin
            if (push) begin
              ctr   <= ctr_inc;
              state <= (count_after < DEPTH) ? S_LAUNCH : S_HOLD;
            end else if (wd_cnt == WD_LAST) begin
              err_timeout <= 1'b1;
              state       <= S_LAUNCH;
            end else begin
              wd_cnt <= wd_cnt + WDW'(1);
            end
          end
          S_HOLD: begin
            if (draining) begin
              if (!m_valid || m_ready) begin
                draining <= 1'b0;
                state    <= S_IDLE;
              end
            end else if (count_after < DEPTH) begin
              state <= S_LAUNCH;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_128_ctr.sv
// Directed bench for aes_128_ctr using SP800-38A CTR and AES(0,0) known answers.
module tb_aes_128_ctr;

  localparam logic [127:0] KEY      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV       = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] AES_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, cfg_load, s_valid, s_ready, s_last, m_valid, m_ready, m_last, busy, err_timeout;
  logic [127:0] cfg_key, cfg_iv, s_data, m_data;
  logic         cfg_load_8, s_valid_8, s_ready_8, s_last_8, m_valid_8, m_ready_8, m_last_8, busy_8, err_timeout_8;
  logic [127:0] cfg_key_8, cfg_iv_8, s_data_8, m_data_8;

  aes_128_ctr dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err_timeout(err_timeout)
  );

  aes_128_ctr #(.CTR_W(8)) dut8 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load_8), .cfg_key(cfg_key_8), .cfg_iv(cfg_iv_8),
    .s_valid(s_valid_8), .s_ready(s_ready_8), .s_data(s_data_8), .s_last(s_last_8),
    .m_valid(m_valid_8), .m_ready(m_ready_8), .m_data(m_data_8), .m_last(m_last_8),
    .busy(busy_8), .err_timeout(err_timeout_8)
  );

  int checks = 0;
  int failures = 0;

  logic [127:0] pt [4];
  logic [127:0] ct [4];
  logic [127:0] tx [64];
  logic [127:0] ex [64];
  logic [127:0] got [64];
  logic         ex_known [64];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] iv);
    @(negedge clk);
    cfg_key  = k;
    cfg_iv   = iv;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) begin
      tx[i] = '0;
      ex[i] = '0;
      ex_known[i] = 1'b0;
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_s_ready"}, 128'(s_ready), 128'(0));
    check_eq({tag, "_m_valid"}, 128'(m_valid), 128'(0));
    check_eq({tag, "_m_data"}, m_data, 128'(0));
    check_eq({tag, "_m_last"}, 128'(m_last), 128'(0));
    check_eq({tag, "_busy"}, 128'(busy), 128'(0));
    check_eq({tag, "_err"}, 128'(err_timeout), 128'(0));
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 400) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, 128'(busy), 128'(0));
  endtask

  // Streams tx[0..n-1] in, compares each delivered beat, and checks the output holds while stalled
  task automatic run_msg(input int n, input bit rnd_ready, input bit with_last, input string tag);
    int sent, rcvd, cyc;
    bit hold_chk, fire_in, fire_out;
    logic [127:0] held;
    sent = 0; rcvd = 0; cyc = 0; hold_chk = 0; held = '0;
    while (rcvd < n && cyc < 3000) begin
      @(negedge clk);
      if (hold_chk) begin
        check_eq({tag, "_stall_valid"}, 128'(m_valid), 128'(1));
        check_eq({tag, "_stall_data"}, m_data, held);
      end
      s_valid = (sent < n);
      s_data  = (sent < n) ? tx[sent] : '0;
      s_last  = with_last && (sent == n - 1);
      m_ready = rnd_ready ? ($urandom_range(99, 0) < 30) : 1'b1;
      #1;
      fire_in  = s_valid && s_ready;
      fire_out = m_valid && m_ready;
      if (fire_out) begin
        got[rcvd] = m_data;
        if (ex_known[rcvd]) check_eq($sformatf("%s_data%0d", tag, rcvd), m_data, ex[rcvd]);
        check_eq($sformatf("%s_last%0d", tag, rcvd), 128'(m_last), 128'(with_last && (rcvd == n - 1)));
        rcvd++;
      end
      hold_chk = m_valid && !m_ready;
      held     = m_data;
      if (fire_in) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    check_eq({tag, "_beats"}, 128'(rcvd), 128'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int c, k, n_in, dups;
    logic [127:0] got8 [2];
    logic last8;

    pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a; ct[0] = 128'h874d6191b620e3261bef6864990db6ce;
    pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; ct[1] = 128'h9806f66b7970fdff8617187bb9fffdff;
    pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; ct[2] = 128'h5ae4df3edbd5d35e5b4f09020db03eab;
    pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710; ct[3] = 128'h1e031dda2fbe03d1792170a0f3009cee;

    rst = 1'b1; cfg_load = 1'b0; cfg_key = '0; cfg_iv = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    cfg_load_8 = 1'b0; cfg_key_8 = '0; cfg_iv_8 = '0;
    s_valid_8 = 1'b0; s_data_8 = '0; s_last_8 = 1'b0; m_ready_8 = 1'b1;
    got8[0] = '0; got8[1] = '0; last8 = 1'b0;

    repeat (3) @(negedge clk);
    #1 check_reset("rst0");
    @(negedge clk);
    rst = 1'b0;

    // Encrypt four SP800-38A blocks; block 2 exercises the ..feff -> ..ff00 carry
    clear_exp();
    for (int i = 0; i < 4; i++) begin tx[i] = pt[i]; ex[i] = ct[i]; ex_known[i] = 1'b1; end
    load(KEY, IV);
    run_msg(4, 1'b0, 1'b1, "enc");
    wait_idle("enc_idle");

    // Ciphertext fed back with a 30% duty downstream ready
    clear_exp();
    for (int i = 0; i < 4; i++) begin tx[i] = ct[i]; ex[i] = pt[i]; ex_known[i] = 1'b1; end
    load(KEY, IV);
    run_msg(4, 1'b1, 1'b1, "dec");
    wait_idle("dec_idle");

    // 64 back-to-back beats of zeros: output is raw keystream, every block must differ
    clear_exp();
    for (int i = 0; i < 4; i++) begin ex[i] = pt[i] ^ ct[i]; ex_known[i] = 1'b1; end
    load(KEY, IV);
    run_msg(64, 1'b0, 1'b1, "c64");
    dups = 0;
    for (int i = 0; i < 64; i++)
      for (int j = i + 1; j < 64; j++)
        if (got[i] == got[j]) dups++;
    check_eq("c64_unique", 128'(dups), 128'(0));
    wait_idle("c64_idle");

    // 8-bit counter: iv 0..0ff wraps to the all-zero block, whose zero-key keystream is known
    @(negedge clk);
    cfg_key_8 = '0; cfg_iv_8 = 128'hff; cfg_load_8 = 1'b1;
    @(negedge clk);
    cfg_load_8 = 1'b0;
    n_in = 0; k = 0; c = 0;
    while (k < 2 && c < 400) begin
      @(negedge clk);
      s_valid_8 = (n_in < 2);
      s_last_8  = (n_in == 1);
      #1;
      if (m_valid_8) begin
        if (k == 1) last8 = m_last_8;
        got8[k] = m_data_8;
        k++;
      end
      if (s_valid_8 && s_ready_8) n_in++;
      c++;
    end
    s_valid_8 = 1'b0;
    s_last_8  = 1'b0;
    check_eq("w8_beats", 128'(k), 128'(2));
    check_eq("w8_wrap_blk", got8[1], AES_ZERO);
    check_eq("w8_last", 128'(last8), 128'(1));
    c = 0;
    while (busy_8 && c < 100) begin @(negedge clk); c++; end
    check_eq("w8_idle", 128'(busy_8), 128'(0));
    check_eq("w8_err", 128'(err_timeout_8), 128'(0));

    // Abort mid-message: pending beat survives, next message uses only the new key/iv
    load(KEY, IV);
    m_ready = 1'b0; s_data = '0; s_last = 1'b0; s_valid = 1'b1;
    c = 0;
    #1;
    while (!s_ready && c < 300) begin @(negedge clk); #1; c++; end
    check_eq("ab_accept", 128'(s_ready), 128'(1));
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check_eq("ab_pending", 128'(m_valid), 128'(1));
    check_eq("ab_busy", 128'(busy), 128'(1));
    load('0, '0);
    #1;
    check_eq("ab_kept_valid", 128'(m_valid), 128'(1));
    check_eq("ab_kept_data", m_data, pt[0] ^ ct[0]);
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("ab_drained", 128'(m_valid), 128'(0));
    clear_exp();
    ex[0] = AES_ZERO; ex_known[0] = 1'b1;
    run_msg(1, 1'b0, 1'b1, "ab_new");
    wait_idle("ab_idle");

    // Reset while the generator is refilling the FIFO
    clear_exp();
    tx[0] = pt[0]; ex[0] = ct[0]; ex_known[0] = 1'b1;
    load(KEY, IV);
    run_msg(1, 1'b0, 1'b0, "rs_pre");
    repeat (30) @(negedge clk);
    check_eq("rs_busy", 128'(busy), 128'(1));
    rst = 1'b1;
    #1 check_reset("rs_mid");
    @(negedge clk);
    rst = 1'b0;
    clear_exp();
    for (int i = 0; i < 2; i++) begin tx[i] = pt[i]; ex[i] = ct[i]; ex_known[i] = 1'b1; end
    load(KEY, IV);
    run_msg(2, 1'b0, 1'b1, "rs_post");
    wait_idle("rs_idle");
    check_eq("final_err", 128'(err_timeout), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
